// File: rtl/sevenseg_scan_reader.sv
`default_nettype none
// ============================================================================
// sevenseg_scan_reader : samples a multiplexed 7-segment bus and rebuilds the
// BCD value per digit. Option SEVENSEG_READER_ACTIVE_LOW_EN inverts the pins.
// Revision: 1.0
// ============================================================================
module sevenseg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    capture_pulse,
    output logic                    frame_valid
);
    localparam int c_vec_w = 7 + NUM_DIGITS;
    localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_vec_w-1:0]    w_pins;
    logic [c_vec_w-1:0]    r_sync1;
    logic [c_vec_w-1:0]    r_sync2;
    logic [c_vec_w-1:0]    r_prev;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_inc;
    logic [NUM_DIGITS-1:0] r_seen;
    logic [NUM_DIGITS-1:0] w_seen_next;
    logic [NUM_DIGITS-1:0] w_sel;
    logic [6:0]            w_seg;
    logic                  w_same;
    logic                  w_onehot;
    logic [5:0]            w_dec;

`ifdef SEVENSEG_READER_ACTIVE_LOW_EN
    assign w_pins = ~{seg_in, dig_sel};
`else
    assign w_pins = {seg_in, dig_sel};
`endif

    // Result layout: {blank, err, digit[3:0]}
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_seg = {2'b00, 4'd0};
            7'b0110000: decode_seg = {2'b00, 4'd1};
            7'b1101101: decode_seg = {2'b00, 4'd2};
            7'b1111001: decode_seg = {2'b00, 4'd3};
            7'b0110011: decode_seg = {2'b00, 4'd4};
            7'b1011011: decode_seg = {2'b00, 4'd5};
            7'b1011111: decode_seg = {2'b00, 4'd6};
            7'b1110000: decode_seg = {2'b00, 4'd7};
            7'b1111111: decode_seg = {2'b00, 4'd8};
            7'b1111011: decode_seg = {2'b00, 4'd9};
            7'b0000000: decode_seg = {2'b10, 4'hF};
            default:    decode_seg = {2'b01, 4'hE};
        endcase
    endfunction

    assign w_seg       = r_sync2[c_vec_w-1 -: 7];
    assign w_sel       = r_sync2[NUM_DIGITS-1:0];
    assign w_same      = (r_sync2 == r_prev);
    assign w_onehot    = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
    assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_w'(1);
    assign w_seen_next = r_seen | w_sel;
    assign w_dec       = decode_seg(w_seg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_prev        <= '0;
            r_cnt         <= '0;
            r_seen        <= '0;
            r_state       <= S_IDLE;
            digits        <= '0;
            blank         <= '1;
            err           <= '0;
            capture_pulse <= 1'b0;
            frame_valid   <= 1'b0;
        end else begin
            r_sync1       <= w_pins;
            r_sync2       <= r_sync1;
            r_prev        <= r_sync2;
            capture_pulse <= 1'b0;
            frame_valid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_onehot) r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!w_same) begin
                        r_cnt <= '0;
                        if (!w_onehot) r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // The slot is written on the edge that completes the count
                        if (w_cnt_inc == c_cnt_max) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (w_sel[i]) begin
                                    digits[4*i +: 4] <= w_dec[3:0];
                                    blank[i]         <= w_dec[5];
                                    err[i]           <= w_dec[4];
                                end
                            end
                            capture_pulse <= 1'b1;
                            if (&w_seen_next) begin
                                frame_valid <= 1'b1;
                                r_seen      <= '0;
                            end else begin
                                r_seen <= w_seen_next;
                            end
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE, S_HOLD: begin
                    if (!w_same) begin
                        r_cnt   <= '0;
                        r_state <= w_onehot ? S_SETTLE : S_IDLE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= S_HOLD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_reader.sv
`default_nettype none
// ============================================================================
// tb_sevenseg_scan_reader : randomized scan phases against a phase-level model
// with a capture scoreboard. Revision: 1.0
// ============================================================================
module tb_sevenseg_scan_reader;
    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [6:0]    seg_in  = '0;
    logic [ND-1:0] dig_sel = '0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] blank;
    logic [ND-1:0] err;
    logic          capture_pulse;
    logic          frame_valid;

    sevenseg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk           (clk),
        .reset         (reset),
        .seg_in        (seg_in),
        .dig_sel       (dig_sel),
        .digits        (digits),
        .blank         (blank),
        .err           (err),
        .capture_pulse (capture_pulse),
        .frame_valid   (frame_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [4*ND-1:0] dig;
        logic [ND-1:0]  blk;
        logic [ND-1:0]  er;
        logic           fv;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;

    logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    logic [3:0]      m_dig [ND];
    logic [ND-1:0]   m_blank;
    logic [ND-1:0]   m_err;
    logic [ND-1:0]   m_seen;
    logic [6+ND:0]   last_vec;
    logic [4*ND-1:0] snap;

    // {blank, err, digit}
    function automatic logic [5:0] model_dec(input logic [6:0] seg);
        for (int i = 0; i < 10; i++)
            if (seg == codes[i]) return {2'b00, 4'(i)};
        if (seg == 7'd0) return {2'b10, 4'hF};
        return {2'b01, 4'hE};
    endfunction

    function automatic logic [4*ND-1:0] pack_dig();
        logic [4*ND-1:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
        m_blank  = '1;
        m_err    = '0;
        m_seen   = '0;
        last_vec = '0;
        expq.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // A phase holds one bus value for len clock edges; it must differ from the previous one.
    task automatic phase(input logic [ND-1:0] sel, input logic [6:0] seg, input int len);
        exp_t e;
        logic [5:0] d;
        if ($countones(sel) == 1 && len >= SC + 1) begin
            d = model_dec(seg);
            for (int i = 0; i < ND; i++) begin
                if (sel[i]) begin
                    m_dig[i]   = d[3:0];
                    m_blank[i] = d[5];
                    m_err[i]   = d[4];
                end
            end
            m_seen = m_seen | sel;
            e.fv   = (m_seen == '1);
            if (e.fv) m_seen = '0;
            e.cyc  = cyc + 3 + SC;
            e.dig  = pack_dig();
            e.blk  = m_blank;
            e.er   = m_err;
            expq.push_back(e);
        end
        last_vec = {seg, sel};
        seg_in   = seg;
        dig_sel  = sel;
        repeat (len) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                total++;
                bad++;
                $display("FAIL missed_capture: no capture_pulse, required one at cycle %0d", mon_e.cyc);
            end
            if (capture_pulse) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_capture: capture_pulse at cycle %0d, required none", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_e.cyc != cyc || digits !== mon_e.dig || blank !== mon_e.blk ||
                        err !== mon_e.er || frame_valid !== mon_e.fv) begin
                        bad++;
                        $display("FAIL capture: got cyc=%0d digits=%h blank=%b err=%b frame=%b, required cyc=%0d digits=%h blank=%b err=%b frame=%b",
                                 cyc, digits, blank, err, frame_valid,
                                 mon_e.cyc, mon_e.dig, mon_e.blk, mon_e.er, mon_e.fv);
                    end
                end
            end else if (frame_valid) begin
                total++;
                bad++;
                $display("FAIL stray_frame: frame_valid=1 without capture_pulse at cycle %0d, required 0", cyc);
            end
        end
    end

    initial begin
        model_reset();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_digits", 32'(digits), 32'h0000);
            check("reset_blank", 32'(blank), 32'hF);
            check("reset_err_strobes", {err, capture_pulse, frame_valid}, 32'h0);
        end
        @(posedge clk);
        #1;

        phase(4'b0001, 7'b1011011, 10);
        check("digit0_is_5", 32'(digits[3:0]), 32'h5);
        check("blank0_clear", 32'(blank[0]), 32'h0);

        phase(4'b0001, codes[1], 10);
        phase(4'b0010, codes[2], 10);
        phase(4'b0100, codes[3], 10);
        phase(4'b1000, codes[4], 10);
        check("scan_4321", 32'(digits), 32'h4321);

        phase(4'b0100, 7'b1001001, 10);
        check("bad_pattern_digit", 32'(digits[11:8]), 32'hE);
        check("bad_pattern_err", 32'(err[2]), 32'h1);
        phase(4'b0100, 7'b0000000, 10);
        check("blank_digit", 32'(digits[11:8]), 32'hF);
        check("blank_flags", {blank[2], err[2]}, 32'b10);

        snap = digits;
        phase(4'b0010, codes[7], 3);
        phase(4'b0011, codes[8], 10);
        phase(4'b0000, codes[9], 10);
        phase(4'b0001, codes[6], SC);
        check("glitch_no_write", 32'(digits), 32'(snap));
        phase(4'b0010, codes[0], SC + 1);
        phase(4'b1000, codes[9], 10);

        seg_in   = codes[2];
        dig_sel  = 4'b0010;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_digits", 32'(digits), 32'h0000);
        check("midreset_blank", 32'(blank), 32'hF);
        check("midreset_err_strobes", {err, capture_pulse, frame_valid}, 32'h0);
        model_reset();
        seg_in  = '0;
        dig_sel = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        phase(4'b0010, codes[2], 10);
        check("post_reset_capture", 32'(digits), 32'h0020);

        for (int k = 0; k < 80; k++) begin
            logic [ND-1:0] s;
            logic [6:0]    g;
            int            r;
            r = $urandom_range(0, 9);
            if (r < 7) s = ND'(1) << $urandom_range(0, ND - 1);
            else       s = ND'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 7)       g = codes[$urandom_range(0, 9)];
            else if (r == 7) g = 7'd0;
            else             g = 7'($urandom);
            if ({g, s} == last_vec) g = g ^ 7'b0000001;
            phase(s, g, $urandom_range(2, 12));
        end

        repeat (SC + 6) @(posedge clk);
        #1;
        check("final_digits", 32'(digits), 32'(pack_dig()));
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
